// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder scan controller: FSM state encoding
// and the cyclic "next set bit" search used to step through enabled channels.
package decoder_scan_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_BLANK_ENC = 2'd1;
  localparam logic [1:0] ST_DWELL_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_BLANK = ST_BLANK_ENC,
    S_DWELL = ST_DWELL_ENC
  } state_e;

  // Search result: next channel index and whether the search wrapped
  // past channel 7 (or landed back on the current channel).
  typedef struct packed {
    logic       wrap;
    logic [2:0] idx;
  } next_ch_t;

  // Find the first set bit of m strictly above cur, wrapping 7->0.
  // The eighth candidate is cur itself, so a single-bit mask reselects it.
  // An all-zero mask returns cur with wrap set.
  function automatic next_ch_t next_set_bit(input logic [7:0] m, input logic [2:0] cur);
    next_ch_t   r;
    logic       found;
    logic [2:0] cand;
    r.idx = cur;
    r.wrap = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = cur + 3'(i);
      if (!found && m[cand]) begin
        found  = 1'b1;
        r.idx  = cand;
        r.wrap = (cand <= cur);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/next_chan_sel.sv
// Combinational cyclic channel search: next enabled channel after cur.
module next_chan_sel
  import decoder_scan_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] nxt,
  output logic       wrap
);

  next_ch_t res;

  // Evaluate the shared search function and split the result.
  always_comb begin
    res  = next_set_bit(mask, cur);
    nxt  = res.idx;
    wrap = res.wrap;
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller for a 3-to-8 decoder: walks the enabled channels, holding
// the enable low for BLANK cycles after each select change and high for
// DWELL cycles, so the select lines never move while the decoder is enabled.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       single,
  input  logic [7:0] mask,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       en,
  output logic       busy,
  output logic       pass_done
);

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK - 1);
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] sel_q;
  logic       en_q;
  logic       pass_done_q;
  logic [7:0] mask_q;
  logic       single_q;

  logic [7:0] srch_mask;
  logic [2:0] srch_cur;
  logic [2:0] nxt_chan;
  logic       nxt_wrap;

  // In IDLE the search starts "after channel 7" on the live mask, which
  // yields the lowest set bit; while scanning it steps from the current
  // channel through the latched mask.
  always_comb begin
    srch_mask = mask_q;
    srch_cur  = sel_q;
    if (state_q == S_IDLE) begin
      srch_mask = mask;
      srch_cur  = 3'd7;
    end
  end

  next_chan_sel u_next_chan_sel (
    .mask (srch_mask),
    .cur  (srch_cur),
    .nxt  (nxt_chan),
    .wrap (nxt_wrap)
  );

  // Scan FSM with duration counter and registered decoder drive.
  // Select only changes on edges where en is (or becomes) low; after a
  // single pass the select holds on the last channel scanned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      en_q        <= 1'b0;
      pass_done_q <= 1'b0;
      mask_q      <= '0;
      single_q    <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          en_q <= 1'b0;
          if (start && !stop && (mask != 8'd0)) begin
            mask_q   <= mask;
            single_q <= single;
            sel_q    <= nxt_chan;
            cnt_q    <= BLANK_LOAD;
            state_q  <= S_BLANK;
          end
        end
        S_BLANK: begin
          if (stop) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == 8'd0) begin
            state_q <= S_DWELL;
            cnt_q   <= DWELL_LOAD;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DWELL: begin
          if (stop) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == 8'd0) begin
            en_q <= 1'b0;
            if (nxt_wrap) begin
              // Dwell on the highest enabled channel just finished.
              pass_done_q <= 1'b1;
              if (single_q) begin
                state_q <= S_IDLE;
              end else begin
                sel_q   <= nxt_chan;
                cnt_q   <= BLANK_LOAD;
                state_q <= S_BLANK;
              end
            end else begin
              sel_q   <= nxt_chan;
              cnt_q   <= BLANK_LOAD;
              state_q <= S_BLANK;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign A         = sel_q[2];
  assign B         = sel_q[1];
  assign C         = sel_q[0];
  assign en        = en_q;
  assign pass_done = pass_done_q;
  assign busy      = (state_q != S_IDLE);

endmodule
